// File: rtl/pico_oversample_rx.sv
// pico_oversample_rx -- single-clock receiver for a PICO (SPI-like) stream.
// sclk and serial_in are asynchronous; both are synchronised into iclk and
// sclk is oversampled to find rising edges. The first byte of a transaction
// is the target address, each following byte is written to the current
// address, which then auto-increments. The transaction ends when sclk has
// shown no rising edge for IDLE_CYCLES iclk cycles.
//
// Ports
//   iclk               in   sole clock
//   rst                in   synchronous active-high reset
//   sclk               in   async serial clock (sampled as data)
//   serial_in          in   async serial data, LSB first
//   msg_flag           out  transaction active (ADDR or DATA)
//   mux_control_signal out  [7:0] current target address
//   write_data         out  [7:0] last completed data byte
//   write_strobe       out  1-cycle pulse: write_data valid for address
//   sclk_stop          out  1-cycle pulse on idle timeout
//   addr_err           out  sticky out-of-range address flag
//
// Optional build macro PICO_RX_ADDR_GUARD_EN: addresses above ADDR_MAX
// suppress writes, freeze the pointer and set addr_err (cleared by rst or
// the next timeout). Without it addr_err is constant 0 and the pointer wraps.

module pico_oversample_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int IDLE_CYCLES = 64,
    parameter int ADDR_MAX    = 59
) (
    input  logic       iclk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       serial_in,
    output logic       msg_flag,
    output logic [7:0] mux_control_signal,
    output logic [7:0] write_data,
    output logic       write_strobe,
    output logic       sclk_stop,
    output logic       addr_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic [9:0] IDLE_LAST = 10'(IDLE_CYCLES - 1);

    // Elaboration-time parameter range checks.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES out of range 2..4");
    end
    if (IDLE_CYCLES < 4 || IDLE_CYCLES > 1023) begin : g_bad_idle
        $error("IDLE_CYCLES out of range 4..1023");
    end
    if (ADDR_MAX < 0 || ADDR_MAX > 255) begin : g_bad_addr
        $error("ADDR_MAX out of range 0..255");
    end

    // Input synchronisers.
    logic [SYNC_STAGES-1:0] sclk_sync_q, din_sync_q;
    logic                   sclk_prev_q;

    // Edge and its data bit are registered once more so the FSM works from
    // clean flops; this stage is part of the SYNC_STAGES+2 latency.
    logic       edge_q, edge_d;
    logic       bit_q, bit_d;

    logic [1:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [9:0] idle_cnt_q, idle_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] mux_q, mux_d;
    logic [7:0] wdata_q, wdata_d;
    logic       msg_q, msg_d;
    logic       strobe_q, strobe_d;
    logic       stop_q, stop_d;
    logic       timeout;
    logic [7:0] byte_w;

`ifdef PICO_RX_ADDR_GUARD_EN
    localparam logic [8:0] ADDR_LIM = 9'(ADDR_MAX);
    logic       aerr_q, aerr_d;
`endif

    always_comb begin
        edge_d     = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
        bit_d      = din_sync_q[SYNC_STAGES-1];

        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        mux_d      = mux_q;
        wdata_d    = wdata_q;
        msg_d      = msg_q;
        strobe_d   = 1'b0;
        stop_d     = 1'b0;
`ifdef PICO_RX_ADDR_GUARD_EN
        aerr_d     = aerr_q;
`endif

        // LSB first: new bit enters at the top and walks down to bit 0.
        byte_w     = {bit_q, shift_q[7:1]};

        // An edge always wins over a same-cycle timeout.
        timeout    = (state_q != ST_IDLE) && !edge_q && (idle_cnt_q == IDLE_LAST);
        idle_cnt_d = (edge_q || state_q == ST_IDLE) ? 10'd0 : idle_cnt_q + 10'd1;

        // Pointer advances the cycle after a strobe.
        if (strobe_q) begin
`ifdef PICO_RX_ADDR_GUARD_EN
            if ({1'b0, mux_q} + 9'd1 > ADDR_LIM) aerr_d = 1'b1;
            else                                 mux_d  = mux_q + 8'd1;
`else
            mux_d = mux_q + 8'd1;
`endif
        end

        case (state_q)
            ST_IDLE: begin
                if (edge_q) begin
                    shift_d   = {bit_q, 7'd0};
                    bit_cnt_d = 3'd1;
                    state_d   = ST_ADDR;
                    msg_d     = 1'b1;
                end
            end
            ST_ADDR, ST_DATA: begin
                if (timeout) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 3'd0;
                    shift_d   = 8'd0;
                    mux_d     = 8'd0;
                    msg_d     = 1'b0;
                    stop_d    = 1'b1;
`ifdef PICO_RX_ADDR_GUARD_EN
                    aerr_d    = 1'b0;
`endif
                end else if (edge_q) begin
                    shift_d   = byte_w;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (state_q == ST_ADDR) begin
                            state_d = ST_DATA;
`ifdef PICO_RX_ADDR_GUARD_EN
                            if ({1'b0, byte_w} > ADDR_LIM) aerr_d = 1'b1;
                            else                           mux_d  = byte_w;
`else
                            mux_d = byte_w;
`endif
                        end else begin
                            wdata_d = byte_w;
`ifdef PICO_RX_ADDR_GUARD_EN
                            strobe_d = ~aerr_d;
`else
                            strobe_d = 1'b1;
`endif
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                msg_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iclk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            din_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            edge_q      <= 1'b0;
            bit_q       <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            idle_cnt_q  <= 10'd0;
            shift_q     <= 8'd0;
            mux_q       <= 8'd0;
            wdata_q     <= 8'd0;
            msg_q       <= 1'b0;
            strobe_q    <= 1'b0;
            stop_q      <= 1'b0;
`ifdef PICO_RX_ADDR_GUARD_EN
            aerr_q      <= 1'b0;
`endif
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], serial_in};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            edge_q      <= edge_d;
            bit_q       <= bit_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            shift_q     <= shift_d;
            mux_q       <= mux_d;
            wdata_q     <= wdata_d;
            msg_q       <= msg_d;
            strobe_q    <= strobe_d;
            stop_q      <= stop_d;
`ifdef PICO_RX_ADDR_GUARD_EN
            aerr_q      <= aerr_d;
`endif
        end
    end

    assign msg_flag           = msg_q;
    assign mux_control_signal = mux_q;
    assign write_data         = wdata_q;
    assign write_strobe       = strobe_q;
    assign sclk_stop          = stop_q;
`ifdef PICO_RX_ADDR_GUARD_EN
    assign addr_err           = aerr_q;
`else
    assign addr_err           = 1'b0;
`endif

endmodule

// File: tb/tb_pico_oversample_rx.sv
module tb_pico_oversample_rx;

    logic       iclk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       serial_in;
    logic       msg_flag;
    logic [7:0] mux_control_signal;
    logic [7:0] write_data;
    logic       write_strobe;
    logic       sclk_stop;
    logic       addr_err;

    pico_oversample_rx #(.SYNC_STAGES(2), .IDLE_CYCLES(64), .ADDR_MAX(59)) dut (
        .iclk(iclk), .rst(rst), .sclk(sclk), .serial_in(serial_in),
        .msg_flag(msg_flag), .mux_control_signal(mux_control_signal),
        .write_data(write_data), .write_strobe(write_strobe),
        .sclk_stop(sclk_stop), .addr_err(addr_err)
    );

    always #5 iclk = ~iclk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_rise = 0;

    // Strobe / stop log
    int ns = 0;
    int nstop = 0;
    int s_addr [32];
    int s_data [32];
    int s_cyc  [32];

    always @(posedge iclk) cyc = cyc + 1;

    always @(negedge iclk) begin
        if (write_strobe && ns < 32) begin
            s_addr[ns] = int'(mux_control_signal);
            s_data[ns] = int'(write_data);
            s_cyc[ns]  = cyc;
        end
        if (write_strobe) ns = ns + 1;
        if (sclk_stop) nstop = nstop + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge iclk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input int half);
        serial_in = b;
        sclk      = 1'b1;
        last_rise = cyc;
        tick(half);
        sclk      = 1'b0;
        tick(half);
    endtask

    task automatic send_byte(input logic [7:0] v, input int half);
        for (int i = 0; i < 8; i++) send_bit(v[i], half);
    endtask

    int n0, st0;

    initial begin
        rst = 1'b1; sclk = 1'b0; serial_in = 1'b0;
        tick(3);
        chk("rst_mux",    int'(mux_control_signal), 0);
        chk("rst_wdata",  int'(write_data), 0);
        chk("rst_msg",    int'(msg_flag), 0);
        chk("rst_strobe", int'(write_strobe), 0);
        chk("rst_stop",   int'(sclk_stop), 0);
        chk("rst_aerr",   int'(addr_err), 0);
        rst = 1'b0;
        tick(4);

        // Single write 0x02 <- 0xA5, latency check
        n0 = ns; st0 = nstop;
        send_byte(8'h02, 4);
        chk("t1_ptr_loaded", int'(mux_control_signal), 2);
        chk("t1_msg",        int'(msg_flag), 1);
        send_byte(8'hA5, 4);
        chk("t1_nstrobe", ns - n0, 1);
        chk("t1_addr",    s_addr[n0], 2);
        chk("t1_data",    s_data[n0], 8'hA5);
        chk("t1_latency", s_cyc[n0] - last_rise, 4);
        chk("t1_ptr_inc", int'(mux_control_signal), 3);
        tick(80);
        chk("t1_stop",    nstop - st0, 1);
        chk("t1_msg_off", int'(msg_flag), 0);
        chk("t1_ptr_clr", int'(mux_control_signal), 0);
        chk("t1_wd_keep", int'(write_data), 8'hA5);

        // Burst at 0x04
        n0 = ns;
        send_byte(8'h04, 4);
        send_byte(8'h11, 4);
        send_byte(8'h22, 4);
        send_byte(8'h33, 4);
        chk("t2_nstrobe", ns - n0, 3);
        chk("t2_a0", s_addr[n0],   4); chk("t2_d0", s_data[n0],   8'h11);
        chk("t2_a1", s_addr[n0+1], 5); chk("t2_d1", s_data[n0+1], 8'h22);
        chk("t2_a2", s_addr[n0+2], 6); chk("t2_d2", s_data[n0+2], 8'h33);
        chk("t2_ptr", int'(mux_control_signal), 7);
        tick(80);

        // Partial byte then idle timeout
        n0 = ns; st0 = nstop;
        send_byte(8'h01, 4);
        send_bit(1'b1, 4); send_bit(1'b0, 4); send_bit(1'b1, 4);
        send_bit(1'b1, 4); send_bit(1'b0, 4);
        chk("t3_ptr",     int'(mux_control_signal), 1);
        chk("t3_msg_on",  int'(msg_flag), 1);
        tick(100);
        chk("t3_nstrobe", ns - n0, 0);
        chk("t3_stop",    nstop - st0, 1);
        chk("t3_msg_off", int'(msg_flag), 0);
        chk("t3_ptr_clr", int'(mux_control_signal), 0);
        chk("t3_wd_keep", int'(write_data), 8'h33);

        // Reset mid-byte
        n0 = ns; st0 = nstop;
        send_byte(8'h03, 4);
        send_bit(1'b1, 4); send_bit(1'b1, 4); send_bit(1'b0, 4); send_bit(1'b1, 4);
        rst = 1'b1;
        tick(1);
        chk("t4_mux",  int'(mux_control_signal), 0);
        chk("t4_wd",   int'(write_data), 0);
        chk("t4_msg",  int'(msg_flag), 0);
        chk("t4_stb",  int'(write_strobe), 0);
        chk("t4_stop", int'(sclk_stop), 0);
        chk("t4_aerr", int'(addr_err), 0);
        rst = 1'b0;
        tick(100);
        chk("t4_nstrobe", ns - n0, 0);
        chk("t4_nstop",   nstop - st0, 0);

        // Fast sclk: next edge lands the cycle after each strobe
        n0 = ns;
        send_byte(8'h10, 1);
        send_byte(8'h96, 1);
        send_byte(8'h69, 1);
        tick(4);
        chk("t5_nstrobe", ns - n0, 2);
        chk("t5_a0", s_addr[n0],   8'h10); chk("t5_d0", s_data[n0],   8'h96);
        chk("t5_a1", s_addr[n0+1], 8'h11); chk("t5_d1", s_data[n0+1], 8'h69);
        tick(80);

        // Address limit
        n0 = ns;
        send_byte(8'h3B, 4);
        send_byte(8'h5A, 4);
        send_byte(8'hC3, 4);
        chk("t6_a0", s_addr[n0], 59);
        chk("t6_d0", s_data[n0], 8'h5A);
`ifdef PICO_RX_ADDR_GUARD_EN
        chk("t6_nstrobe", ns - n0, 1);
        chk("t6_aerr",    int'(addr_err), 1);
        chk("t6_ptr",     int'(mux_control_signal), 59);
`else
        chk("t6_nstrobe", ns - n0, 2);
        chk("t6_a1",      s_addr[n0+1], 60);
        chk("t6_d1",      s_data[n0+1], 8'hC3);
        chk("t6_aerr",    int'(addr_err), 0);
        chk("t6_ptr",     int'(mux_control_signal), 61);
`endif
        tick(80);
        chk("t6_aerr_clr", int'(addr_err), 0);
        chk("t6_ptr_clr",  int'(mux_control_signal), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pico_oversample_rx.md
PICO_OVERSAMPLE_RX -- requirements
Module: pico_oversample_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flops in each input synchronizer for sclk and serial_in; legal range 2..4.
REQ-002 Parameter IDLE_CYCLES, default 64: consecutive iclk cycles with no detected sclk rising edge that end a transaction; legal range 4..1023.
REQ-003 Parameter ADDR_MAX, default 59: highest valid register address; used only when PICO_RX_ADDR_GUARD_EN is defined.
REQ-004 iclk  input  1  sole clock; all state updates on its rising edge; one clock, reset synchronous and active-high.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 sclk  input  1  asynchronous SPI clock, oversampled as data.
REQ-007 serial_in  input  1  asynchronous PICO data, sampled on detected sclk rising edges.
REQ-008 msg_flag  output  1  high while a transaction is active (state ADDR or DATA).
REQ-009 mux_control_signal  output  8  current target address pointer.
REQ-010 write_data  output  8  last completed data byte.
REQ-011 write_strobe  output  1  one-cycle pulse: write_data valid for address mux_control_signal.
REQ-012 sclk_stop  output  1  one-cycle pulse at transaction end by idle timeout.
REQ-013 addr_err  output  1  sticky flag, see REQ-030; tied 0 when guard disabled.

Function
REQ-014 sclk and serial_in SHALL each pass through a SYNC_STAGES-deep synchronizer; an edge is registered when synchronized sclk is 1 and its previous value was 0.
REQ-015 On an edge cycle the synchronized serial_in bit SHALL be shifted in LSB first (first bit received = bit 0).
REQ-016 FSM states: IDLE, ADDR, DATA; reset state IDLE.
REQ-017 IDLE: an edge captures bit 0 of the address byte and moves to ADDR; bit counter = 1.
REQ-018 ADDR: on the 8th bit, mux_control_signal SHALL load the assembled byte the next cycle, bit counter clears, state -> DATA.
REQ-019 DATA: on the 8th bit, write_data SHALL load the byte and write_strobe SHALL pulse high the next cycle, with mux_control_signal still holding that byte's address.
REQ-020 The cycle after write_strobe, mux_control_signal SHALL increment by 1, modulo 256 (255 -> 0) when guard disabled.
REQ-021 Idle counter SHALL clear on every edge and in IDLE, else increment; when it reaches IDLE_CYCLES, sclk_stop pulses one cycle, state -> IDLE.
REQ-022 On timeout: partial byte and bit counter discarded, mux_control_signal cleared to 0, write_data retained, no write_strobe.
REQ-023 Edge and counter reaching IDLE_CYCLES in the same cycle: edge wins, no timeout.
REQ-024 Edge arriving the cycle after a write_strobe SHALL be captured normally (back-to-back bytes, no lost bit).
REQ-025 msg_flag SHALL be registered: high from the cycle after the first edge until the cycle sclk_stop pulses (inclusive of neither edge of IDLE).
REQ-026 Total latency: raw sclk rising edge of 8th bit to write_strobe = SYNC_STAGES + 2 iclk cycles.

Reset
REQ-027 rst high at an iclk edge SHALL force: state IDLE, all counters 0, shift reg 0, synchronizers 0, mux_control_signal 0, write_data 0, msg_flag 0, write_strobe 0, sclk_stop 0, addr_err 0.
REQ-028 rst asserted mid-byte SHALL discard the byte with no strobe; no sclk_stop pulse is generated by reset.
REQ-029 rst SHALL take priority over every other event in the same cycle.

Configuration
REQ-030 Macro PICO_RX_ADDR_GUARD_EN defined: addresses > ADDR_MAX (loaded or incremented) SHALL suppress write_strobe, hold pointer at its value, set addr_err until rst or next timeout; undefined: no check, pointer wraps per REQ-020, addr_err constant 0.

Verification
REQ-031 Address 0x02 then data 0xA5, sclk period 8 iclk -> one write_strobe, mux_control_signal=2, write_data=0xA5, strobe SYNC_STAGES+2 cycles after 16th raw edge.
REQ-032 Address 0x04 then 3 data bytes 0x11,0x22,0x33 -> strobes at addresses 4,5,6 with matching data; pointer=7 after last.
REQ-033 Address 0x01, 5 data bits, then sclk idle 64 cycles -> no strobe, sclk_stop one pulse, msg_flag falls, pointer=0, write_data unchanged.
REQ-034 rst pulse after 4 data bits of byte at address 0x03 -> all outputs reset next cycle, no strobe, no sclk_stop.
REQ-035 Guard on, address 0x3B (59) then 2 data bytes -> first strobes at 59; second suppressed, addr_err=1; guard off -> second strobes at 60.
